mul_div_unit: RTL and testbench

//  Iterative 32-bit multiply/divide engine in the EX stage, directly upstream of the HI/LO register file.

---
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mul_div_unit.sv | 129 ++++++++++++
 tb/tb_mul_div_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide engine.
// The master side issues operations; the slave side is the engine producing HI/LO results.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic             cancel_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic             hi_we_o;
    logic             lo_we_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, src_a_i, src_b_i, cancel_i,
        input  ready_o, busy_o, done_o, hi_we_o, lo_we_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src_a_i, src_b_i, cancel_i,
        output ready_o, busy_o, done_o, hi_we_o, lo_we_o, hi_o, lo_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: one bit per cycle on magnitudes, sign fix-up at the end,
// one-cycle HI/LO write strobe on completion (suppressible by a same-cycle cancel).
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               sa_q;
    logic               sb_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    function automatic logic [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic signed [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    logic               sgn_a_d;
    logic               sgn_b_d;
    logic [WIDTH-1:0]   abs_a_d;
    logic [WIDTH-1:0]   abs_b_d;
    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]     div_part_d;
    logic [WIDTH:0]     div_diff_d;
    logic [2*WIDTH-1:0] div_acc_d;
    logic               last_d;

    always_comb begin
        sgn_a_d = ~bus.op_i[0] & bus.src_a_i[WIDTH-1];
        sgn_b_d = ~bus.op_i[0] & bus.src_b_i[WIDTH-1];
        abs_a_d = neg_w(bus.src_a_i, sgn_a_d);
        abs_b_d = neg_w(bus.src_b_i, sgn_b_d);
        // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
        mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};
        // Divide: partial remainder needs one extra bit since it can reach 2*divisor-1.
        div_part_d = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff_d = div_part_d - {1'b0, b_q};
        div_acc_d  = div_diff_d[WIDTH] ? {div_part_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        last_d = (cnt_q == CNT_W'(WIDTH-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i && !bus.cancel_i) begin
                        a_q     <= abs_a_d;
                        b_q     <= abs_b_d;
                        sa_q    <= sgn_a_d;
                        sb_q    <= sgn_b_d;
                        cnt_q   <= '0;
                        acc_q   <= {{WIDTH{1'b0}}, (bus.op_i[1] ? abs_a_d : abs_b_d)};
                        state_q <= bus.op_i[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (bus.cancel_i) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= mul_acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_d) begin
                            {hi_q, lo_q} <= neg_2w(mul_acc_d, sa_q ^ sb_q);
                            state_q      <= DONE;
                        end
                    end
                end
                DIV: begin
                    if (bus.cancel_i) begin
                        state_q <= IDLE;
                    end else if (b_q == '0) begin
                        // Divide by zero: hand back the dividend as given and an all-ones quotient.
                        hi_q    <= neg_w(a_q, sa_q);
                        lo_q    <= '1;
                        state_q <= DONE;
                    end else begin
                        acc_q <= div_acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_d) begin
                            lo_q    <= neg_w(div_acc_d[WIDTH-1:0], sa_q ^ sb_q);
                            hi_q    <= neg_w(div_acc_d[2*WIDTH-1:WIDTH], sa_q);
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.done_o  = (state_q == DONE);
    assign bus.hi_we_o = bus.done_o & ~bus.cancel_i;
    assign bus.lo_we_o = bus.done_o & ~bus.cancel_i;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latency, strobe count, cancel and reset.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail = 0;
    int   we_cnt = 0;
    int   we_snap;
    int   lat;

    mul_div_unit_if #(.WIDTH(32)) bus();

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.hi_we_o) we_cnt <= we_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, return with the bench sitting in the DONE cycle (or after the bound).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        bus.op_i    = op;
        bus.src_a_i = a;
        bus.src_b_i = b;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        cycles = 0;
        while (bus.done_o !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic back_to_idle(input string tag);
        @(posedge clk); #1;
        chk({tag, "_ready"}, bus.ready_o, 1'b1);
        chk({tag, "_done_low"}, bus.done_o, 1'b0);
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.cancel_i = 1'b0;
        bus.op_i     = 2'b00;
        bus.src_a_i  = '0;
        bus.src_b_i  = '0;
        rst_n        = 1'b0;
        #12;
        chk("rst_ready", bus.ready_o, 1'b1);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_done", bus.done_o, 1'b0);
        chk("rst_we", {bus.hi_we_o, bus.lo_we_o}, 2'b00);
        chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MULTU max*max: latency, result and single strobe
        we_snap = we_cnt;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        chk("multu_lat", lat, 32);
        chk("multu_hi", bus.hi_o, 32'hFFFFFFFE);
        chk("multu_lo", bus.lo_o, 32'h00000001);
        chk("multu_busy", bus.busy_o, 1'b1);
        chk("multu_we", {bus.hi_we_o, bus.lo_we_o}, 2'b11);
        back_to_idle("multu");
        chk("multu_we_count", we_cnt - we_snap, 1);

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, lat);
        chk("mult_lat", lat, 32);
        chk("mult_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFFFFFF_FFFFFFEB);
        back_to_idle("mult");

        run_op(2'b00, 32'h80000000, 32'h80000000, lat);
        chk("mult_min_hilo", {bus.hi_o, bus.lo_o}, 64'h40000000_00000000);
        back_to_idle("mult_min");

        // Start pulse mid-operation must be ignored; cancel in DONE kills the strobe
        we_snap      = we_cnt;
        bus.op_i     = 2'b01;
        bus.src_a_i  = 32'd3;
        bus.src_b_i  = 32'd5;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        lat = 0;
        repeat (4) begin @(posedge clk); #1; lat++; end
        bus.op_i    = 2'b00;
        bus.src_a_i = 32'd9;
        bus.src_b_i = 32'd9;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        lat++;
        bus.start_i = 1'b0;
        while (bus.done_o !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("ign_lat", lat, 32);
        chk("ign_hilo", {bus.hi_o, bus.lo_o}, 64'd15);
        bus.cancel_i = 1'b1;
        #1;
        chk("done_cancel_we", {bus.hi_we_o, bus.lo_we_o}, 2'b00);
        chk("done_cancel_done", bus.done_o, 1'b1);
        @(posedge clk); #1;
        bus.cancel_i = 1'b0;
        chk("done_cancel_ready", bus.ready_o, 1'b1);
        chk("done_cancel_we_count", we_cnt - we_snap, 0);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat);
        chk("div_lat", lat, 32);
        chk("div_lo", bus.lo_o, 32'hFFFFFFFD);
        chk("div_hi", bus.hi_o, 32'hFFFFFFFF);
        back_to_idle("div");

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
        chk("div_wrap_lo", bus.lo_o, 32'h80000000);
        chk("div_wrap_hi", bus.hi_o, 32'h0);
        back_to_idle("div_wrap");

        run_op(2'b11, 32'd100, 32'd7, lat);
        chk("divu_hilo", {bus.hi_o, bus.lo_o}, {32'd2, 32'd14});
        back_to_idle("divu");

        we_snap = we_cnt;
        run_op(2'b11, 32'd100, 32'd0, lat);
        chk("div0_lat", lat, 1);
        chk("div0_hi", bus.hi_o, 32'h64);
        chk("div0_lo", bus.lo_o, 32'hFFFFFFFF);
        back_to_idle("div0");
        chk("div0_we_count", we_cnt - we_snap, 1);

        // Cancel in flight: results hold, no strobe
        we_snap      = we_cnt;
        bus.op_i     = 2'b11;
        bus.src_a_i  = 32'd100;
        bus.src_b_i  = 32'd7;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("cancel_busy_before", bus.busy_o, 1'b1);
        bus.cancel_i = 1'b1;
        @(posedge clk); #1;
        bus.cancel_i = 1'b0;
        chk("cancel_ready", bus.ready_o, 1'b1);
        chk("cancel_busy", bus.busy_o, 1'b0);
        chk("cancel_hilo", {bus.hi_o, bus.lo_o}, {32'h64, 32'hFFFFFFFF});
        @(posedge clk); #1;
        chk("cancel_we_count", we_cnt - we_snap, 0);

        // Asynchronous reset mid-DIV, then a clean DIV
        bus.op_i     = 2'b10;
        bus.src_a_i  = 32'hFFFFFF9C;
        bus.src_b_i  = 32'd7;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
        chk("arst_ready", bus.ready_o, 1'b1);
        chk("arst_busy", bus.busy_o, 1'b0);
        chk("arst_we", {bus.hi_we_o, bus.lo_we_o}, 2'b00);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b10, 32'hFFFFFF9C, 32'd7, lat);
        chk("post_rst_lat", lat, 32);
        chk("post_rst_hilo", {bus.hi_o, bus.lo_o}, {32'hFFFFFFFE, 32'hFFFFFFF2});
        back_to_idle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
